// File: rtl/wb_gpio_irq_ctrl_if.sv
// ---------------------------------------------------------------------------------------------
// wb_gpio_irq_ctrl_if
//   Wishbone slave-side bus bundle for wb_gpio_irq_ctrl.
//   Signals (named from the slave's point of view):
//     wbs_cyc_i  bus cycle           wbs_stb_i  strobe
//     wbs_we_i   write enable        wbs_sel_i  byte selects [3:0]
//     wbs_adr_i  byte address [31:0] wbs_dat_i  write data [31:0]
//     wbs_ack_o  acknowledge         wbs_dat_o  read data [31:0]
//   Modports: master drives the request side, slave drives ack/read data.
// ---------------------------------------------------------------------------------------------
interface wb_gpio_irq_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------------------------
// wb_gpio_irq_ctrl
//   Wishbone-slave GPIO controller with input synchronisers, per-pin rising/falling edge
//   interrupts (sticky, write-1-to-clear) and an aggregated interrupt line.
//   Ports:
//     wb_clk_i   sole clock
//     wb_rst_i   synchronous active-high reset
//     wbs        Wishbone slave bundle (cyc/stb/we/sel/adr/dat in, ack/dat out)
//     io_active  pad enable; when low pads are parked (out = 0, oeb = all 1s)
//     io_in      pad inputs [N_IO-1:0]
//     io_out     pad outputs [N_IO-1:0]
//     io_oeb     pad output enables, active low [N_IO-1:0]
//     irq        OR of the interrupt status bits
//   Register map (adr[7:3] = register, adr[2] = 32-bit word, adr[1:0] ignored):
//     0 OUT  1 OEB  2 IN (ro)  3 RISE_EN  4 FALL_EN  5 STATUS (w1c)  6 INFO (ro)
// ---------------------------------------------------------------------------------------------
module wb_gpio_irq_ctrl #(
    parameter int unsigned N_IO        = 38,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_gpio_irq_ctrl_if.slave wbs,
    input  logic              io_active,
    input  logic [N_IO-1:0]   io_in,
    output logic [N_IO-1:0]   io_out,
    output logic [N_IO-1:0]   io_oeb,
    output logic              irq
);

    localparam logic [4:0]  RegOut    = 5'd0;
    localparam logic [4:0]  RegOeb    = 5'd1;
    localparam logic [4:0]  RegIn     = 5'd2;
    localparam logic [4:0]  RegRiseEn = 5'd3;
    localparam logic [4:0]  RegFallEn = 5'd4;
    localparam logic [4:0]  RegStatus = 5'd5;
    localparam logic [4:0]  RegInfo   = 5'd6;

    localparam logic [7:0]  InfoNio   = 8'(N_IO);
    localparam logic [31:0] InfoLo    = {16'h6F10, 8'd0, InfoNio};
    localparam logic [31:0] InfoHi    = 32'(SYNC_STAGES);

    // Edge events are enabled once the synchroniser and prev flops hold real pin data.
    localparam logic [2:0]  ArmDone   = 3'(SYNC_STAGES + 1);

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [N_IO-1:0] r_out;
    logic [N_IO-1:0] r_oeb;
    logic [N_IO-1:0] r_rise_en;
    logic [N_IO-1:0] r_fall_en;
    logic [N_IO-1:0] r_status;
    logic [N_IO-1:0] r_sync [SYNC_STAGES];
    logic [N_IO-1:0] r_prev;
    logic [2:0]      r_arm;
    logic            r_ack;
    logic [31:0]     r_dat;

    // -----------------------------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------------------------
    logic            w_req;
    logic            w_commit;
    logic            w_wr;
    logic [4:0]      w_reg_idx;
    logic            w_hi;
    logic [31:0]     w_lane_mask;
    logic [63:0]     w_byte_mask;
    logic [63:0]     w_wdata64;
    logic [N_IO-1:0] w_mask_n;
    logic [N_IO-1:0] w_wdat_n;
    logic [N_IO-1:0] w_w1c;

    assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i
                     & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // A request is served on the edge that raises ack; the cycle with ack high is idle, so a
    // held strobe yields alternating ack cycles.
    assign w_commit  = w_req & ~r_ack;
    assign w_wr      = w_commit & wbs.wbs_we_i;
    assign w_reg_idx = wbs.wbs_adr_i[7:3];
    assign w_hi      = wbs.wbs_adr_i[2];

    always_comb begin
        w_lane_mask = '0;
        for (int k = 0; k < 4; k++) begin
            w_lane_mask[8*k +: 8] = {8{wbs.wbs_sel_i[k]}};
        end
    end

    assign w_byte_mask = w_hi ? {w_lane_mask, 32'd0} : {32'd0, w_lane_mask};
    assign w_wdata64   = {wbs.wbs_dat_i, wbs.wbs_dat_i};
    // Bits at or above N_IO fall off here, so they ignore writes.
    assign w_mask_n    = w_byte_mask[N_IO-1:0];
    assign w_wdat_n    = w_wdata64[N_IO-1:0];

    assign w_w1c = (w_wr && (w_reg_idx == RegStatus)) ? (w_wdat_n & w_mask_n) : '0;

    function automatic logic [N_IO-1:0] merge(input logic [N_IO-1:0] old,
                                              input logic [N_IO-1:0] mask,
                                              input logic [N_IO-1:0] data);
        return (old & ~mask) | (data & mask);
    endfunction

    function automatic logic [63:0] widen(input logic [N_IO-1:0] v);
        logic [63:0] r;
        r = '0;
        r[N_IO-1:0] = v;
        return r;
    endfunction

    // -----------------------------------------------------------------------------------------
    // Input synchroniser, edge detection
    // -----------------------------------------------------------------------------------------
    logic [N_IO-1:0] w_sync;
    logic            w_armed;
    logic [N_IO-1:0] w_rise;
    logic [N_IO-1:0] w_fall;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_armed = (r_arm == ArmDone) & io_active;
    assign w_rise  = w_sync & ~r_prev & r_rise_en & {N_IO{w_armed}};
    assign w_fall  = ~w_sync & r_prev & r_fall_en & {N_IO{w_armed}};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
            r_arm  <= '0;
        end else begin
            r_sync[0] <= io_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
            if (r_arm != ArmDone) begin
                r_arm <= r_arm + 3'd1;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_out     <= '0;
            r_oeb     <= '1;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (w_reg_idx)
                RegOut:    r_out     <= merge(r_out, w_mask_n, w_wdat_n);
                RegOeb:    r_oeb     <= merge(r_oeb, w_mask_n, w_wdat_n);
                RegRiseEn: r_rise_en <= merge(r_rise_en, w_mask_n, w_wdat_n);
                RegFallEn: r_fall_en <= merge(r_fall_en, w_mask_n, w_wdat_n);
                default:   ;
            endcase
        end
    end

    // Event is OR-ed in after the clear, so a same-cycle event beats the W1C.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_w1c) | w_rise | w_fall;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Read path and acknowledge
    // -----------------------------------------------------------------------------------------
    logic [63:0] w_rd64;
    logic [31:0] w_rd32;

    always_comb begin
        w_rd64 = '0;
        case (w_reg_idx)
            RegOut:    w_rd64 = widen(r_out);
            RegOeb:    w_rd64 = widen(r_oeb);
            RegIn:     w_rd64 = widen(w_sync);
            RegRiseEn: w_rd64 = widen(r_rise_en);
            RegFallEn: w_rd64 = widen(r_fall_en);
            RegStatus: w_rd64 = widen(r_status);
            RegInfo:   w_rd64 = {InfoHi, InfoLo};
            default:   w_rd64 = '0;
        endcase
        w_rd32 = w_hi ? w_rd64[63:32] : w_rd64[31:0];
    end

    // Read data is only non-zero during the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_commit;
            r_dat <= (w_commit && !wbs.wbs_we_i) ? w_rd32 : 32'd0;
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;

    // -----------------------------------------------------------------------------------------
    // Pad gating and interrupt
    // -----------------------------------------------------------------------------------------
    assign io_out = io_active ? r_out : '0;
    assign io_oeb = io_active ? r_oeb : '1;
    assign irq    = |r_status;

    logic w_unused_ok;
    assign w_unused_ok = ^{wbs.wbs_adr_i[1:0], w_byte_mask, w_wdata64};

endmodule

// File: tb/tb_wb_gpio_irq_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_wb_gpio_irq_ctrl
//   Directed scenarios followed by randomized bus/pin traffic. A cycle-level reference model
//   (register values as 64-bit words, pin history as a queue) is advanced on every clock and
//   compared with the DUT outputs after each edge.
// ---------------------------------------------------------------------------------------------
module tb_wb_gpio_irq_ctrl;

    localparam int unsigned N       = 38;
    localparam int unsigned S       = 2;
    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [23:0] BASE_HI = 24'h30_0000;
    localparam logic [63:0] NMASK   = (64'd1 << N) - 64'd1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         act = 1'b0;
    logic [N-1:0] pins = '0;
    logic [N-1:0] io_out;
    logic [N-1:0] io_oeb;
    logic         irq;

    wb_gpio_irq_ctrl_if bus ();

    always #5 clk = ~clk;

    wb_gpio_irq_ctrl #(
        .N_IO        (N),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (S)
    ) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs       (bus.slave),
        .io_active (act),
        .io_in     (pins),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq       (irq)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------ reference model ------------------------------------------
    logic [63:0] m_out, m_oeb, m_ren, m_fen, m_sts;
    logic        m_ack;
    logic [31:0] m_dat;
    logic [63:0] m_pin_q[$];   // pin values captured at each edge since reset, newest last
    int          m_edges;

    function automatic void m_reset();
        m_out = '0;
        m_oeb = NMASK;
        m_ren = '0;
        m_fen = '0;
        m_sts = '0;
        m_ack = 1'b0;
        m_dat = '0;
        m_pin_q.delete();
        m_edges = 0;
    endfunction

    // Pin value captured 'lag' edges ago (0 = latest); zero if not yet captured since reset.
    function automatic logic [63:0] m_pin_ago(input int lag);
        if (m_pin_q.size() > lag) return m_pin_q[m_pin_q.size() - 1 - lag];
        return '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] adr);
        logic [63:0] v;
        case (adr[7:3])
            5'd0:    v = m_out;
            5'd1:    v = m_oeb;
            5'd2:    v = m_pin_ago(S - 1);
            5'd3:    v = m_ren;
            5'd4:    v = m_fen;
            5'd5:    v = m_sts;
            5'd6:    v = {32'(S), 16'h6F10, 8'd0, 8'(N)};
            default: v = '0;
        endcase
        return adr[2] ? v[63:32] : v[31:0];
    endfunction

    function automatic logic [63:0] m_apply(input logic [63:0] old, input logic [31:0] adr,
                                            input logic [3:0] sel, input logic [31:0] dat);
        logic [63:0] v = old;
        int base = adr[2] ? 32 : 0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) v[base + 8*k +: 8] = dat[8*k +: 8];
        end
        return v & NMASK;
    endfunction

    // One clock: evaluate model with pre-edge inputs, advance, then compare after the edge.
    task automatic step();
        logic [31:0] a, d;
        logic [3:0]  sel;
        logic        we, req, commit, armed;
        logic [63:0] sync, prev, rise, fall, w1c;
        logic [31:0] rd;
        a      = bus.wbs_adr_i;
        d      = bus.wbs_dat_i;
        sel    = bus.wbs_sel_i;
        we     = bus.wbs_we_i;
        req    = bus.wbs_cyc_i && bus.wbs_stb_i && (a[31:8] == BASE_HI);
        commit = req && !m_ack;
        sync   = m_pin_ago(S - 1);
        prev   = m_pin_ago(S);
        armed  = (m_edges >= S + 1) && act;
        rise   = armed ? (sync & ~prev & m_ren) : '0;
        fall   = armed ? (~sync & prev & m_fen) : '0;
        rd     = m_read(a);
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            w1c = '0;
            if (commit && we) begin
                case (a[7:3])
                    5'd0:    m_out = m_apply(m_out, a, sel, d);
                    5'd1:    m_oeb = m_apply(m_oeb, a, sel, d);
                    5'd3:    m_ren = m_apply(m_ren, a, sel, d);
                    5'd4:    m_fen = m_apply(m_fen, a, sel, d);
                    5'd5:    w1c   = m_apply(64'd0, a, sel, d);
                    default: ;
                endcase
            end
            m_sts = (m_sts & ~w1c) | rise | fall;
            m_ack = commit;
            m_dat = (commit && !we) ? rd : 32'd0;
            m_pin_q.push_back(64'(pins));
            if (m_pin_q.size() > S + 1) void'(m_pin_q.pop_front());
            m_edges++;
        end
        #1;
        check_eq("ack", bus.wbs_ack_o, m_ack);
        check_eq("dat_o", bus.wbs_dat_o, m_dat);
        check_eq("io_out", io_out, act ? m_out : 64'd0);
        check_eq("io_oeb", io_oeb, act ? m_oeb : NMASK);
        check_eq("irq", irq, |m_sts);
    endtask

    // ------------------------------ bus helpers ----------------------------------------------
    task automatic bus_set(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = dat;
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdata);
        bus_set(we, adr, sel, dat);
        step();
        check_eq("xfer_ack", bus.wbs_ack_o, 1'b1);
        rdata = bus.wbs_dat_o;
        bus_idle();
        step();
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] unused_rd;
        wb_xfer(1'b1, adr, sel, dat, unused_rd);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rdata);
        wb_xfer(1'b0, adr, 4'hF, 32'd0, rdata);
    endtask

    // ------------------------------ stimulus -------------------------------------------------
    initial begin
        logic [31:0] rd;
        logic [7:0]  off;
        logic [31:0] adr;
        m_reset();
        bus_idle();
        bus.wbs_adr_i = '0;
        bus.wbs_sel_i = '0;
        bus.wbs_dat_i = '0;
        rst = 1'b1;
        act = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check_eq("rst_irq", irq, 1'b0);
        check_eq("rst_oeb", io_oeb, NMASK);
        check_eq("rst_out", io_out, 64'd0);

        // Identification and reset values
        wb_rd(BASE + 32'h30, rd);
        check_eq("info_lo", rd, 32'h6F10_0026);
        wb_rd(BASE + 32'h08, rd);
        check_eq("oeb_lo", rd, 32'hFFFF_FFFF);
        wb_rd(BASE + 32'h0C, rd);
        check_eq("oeb_hi", rd, 32'h0000_003F);

        // Byte-masked OUT write and pad gating
        wb_wr(BASE + 32'h00, 4'b0011, 32'hA5A5_A5A5);
        wb_wr(BASE + 32'h08, 4'hF, 32'h0);
        check_eq("pad_out", io_out, 64'h0000_A5A5);
        check_eq("pad_oeb", io_oeb, 64'h3F_0000_0000);
        act = 1'b0;
        step();
        check_eq("gate_out", io_out, 64'd0);
        check_eq("gate_oeb", io_oeb, NMASK);
        act = 1'b1;
        step();
        check_eq("ungate_out", io_out, 64'h0000_A5A5);
        check_eq("ungate_oeb", io_oeb, 64'h3F_0000_0000);

        // Rising edge on pin 5
        wb_wr(BASE + 32'h18, 4'hF, 32'h20);
        pins[5] = 1'b1;
        step();
        step();
        check_eq("irq_early", irq, 1'b0);
        step();
        check_eq("irq_rise", irq, 1'b1);
        wb_rd(BASE + 32'h28, rd);
        check_eq("sts_rise", rd, 32'h20);
        wb_rd(BASE + 32'h10, rd);
        check_eq("in_pin5", rd, 32'h20);

        // W1C colliding with a new rising event: event wins
        pins[5] = 1'b0;
        repeat (4) step();
        pins[5] = 1'b1;
        step();
        step();
        bus_set(1'b1, BASE + 32'h28, 4'hF, 32'h20);
        step();
        bus_idle();
        step();
        check_eq("w1c_race", irq, 1'b1);
        wb_wr(BASE + 32'h28, 4'hF, 32'h20);
        check_eq("w1c_clr", irq, 1'b0);
        pins[5] = 1'b0;
        repeat (5) step();
        check_eq("no_fall", irq, 1'b0);

        // Reset landing on a pending write discards it
        bus_set(1'b1, BASE + 32'h00, 4'hF, 32'hFFFF_FFFF);
        rst = 1'b1;
        step();
        check_eq("rst_ack", bus.wbs_ack_o, 1'b0);
        bus_idle();
        rst = 1'b0;
        step();
        wb_rd(BASE + 32'h00, rd);
        check_eq("rst_wr_drop", rd, 32'd0);

        // Pins high through reset release with all rising enables: no events
        pins = '1;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        wb_wr(BASE + 32'h18, 4'hF, 32'hFFFF_FFFF);
        wb_wr(BASE + 32'h1C, 4'hF, 32'hFFFF_FFFF);
        repeat (5) step();
        check_eq("arm_hold", irq, 1'b0);

        // Out-of-window, hole in the window, back-to-back strobe
        bus_set(1'b0, 32'h3000_0100, 4'hF, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("oow_ack", bus.wbs_ack_o, 1'b0);
        end
        bus_idle();
        step();
        wb_rd(BASE + 32'hF8, rd);
        check_eq("hole_rd", rd, 32'd0);
        bus_set(1'b0, BASE + 32'h30, 4'hF, 32'd0);
        check_eq("b2b_0", bus.wbs_ack_o, 1'b0);
        step();
        check_eq("b2b_1", bus.wbs_ack_o, 1'b1);
        step();
        check_eq("b2b_2", bus.wbs_ack_o, 1'b0);
        step();
        check_eq("b2b_3", bus.wbs_ack_o, 1'b1);
        bus_idle();
        step();

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                pins = pins ^ (N'({$urandom(), $urandom()}) & N'({$urandom(), $urandom()})
                               & N'({$urandom(), $urandom()}));
            end
            act = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 299) == 0) begin
                bus_idle();
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else if (r >= 6) begin
                off = {3'($urandom_range(0, 7)), 1'($urandom()), 2'($urandom())};
                if ($urandom_range(0, 19) == 0) off = 8'($urandom());
                adr = {BASE_HI, off};
                wb_xfer(1'($urandom()), adr, 4'($urandom()), $urandom(), rd);
            end else if (r == 5 && $urandom_range(0, 3) == 0) begin
                bus_set(1'($urandom()), {24'($urandom()) | 24'h1, 8'($urandom())},
                        4'hF, $urandom());
                step();
                bus_idle();
                step();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb_gpio_irq_ctrl.md
Name: wb_gpio_irq_ctrl

Overview:
Parametrised Wishbone-slave GPIO controller that sits between the Wishbone bus and the io_in/io_out/io_oeb pad bus in user_project_wrapper. It drives the pads from registers and gates them with a logic-analyser enable. It adds what the fixed-width macro lacks: 2..4-stage input synchronisation, per-pin rising/falling-edge interrupt detection with W1C sticky status, and an aggregated irq output. All widths are set by N_IO.

Parameters:
N_IO, 38, number of GPIO channels (1..64).
BASE_ADDR, 32'h3000_0000, Wishbone window base; the window is 256 bytes and decode uses adr[31:8].
SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_active  in  1  pad enable (la_data_in[1] at top level)
io_in  in  N_IO  pad inputs
io_out  out  N_IO  pad outputs
io_oeb  out  N_IO  pad output-enable, active low
irq  out  1  OR of pending interrupt status

Behaviour:
- Clocking and reset: single clock wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values:
  - OUT = 0, OEB = all 1s, RISE_EN = 0, FALL_EN = 0, STATUS = 0.
  - Synchroniser and previous-sample flops = 0; arm counter = 0.
  - wbs_ack_o = 0, wbs_dat_o = 0, irq = 0.
- Register map: offset = adr[7:0]. adr[7:3] selects the register; adr[2] selects word (0 = bits 31:0, 1 = bits 63:32); adr[1:0] ignored.
  - 0 OUT (RW)
  - 1 OEB (RW)
  - 2 IN (RO, synchronised value)
  - 3 RISE_EN (RW)
  - 4 FALL_EN (RW)
  - 5 STATUS (RW1C)
  - 6 INFO (RO): low word = {16'h6F10, 8'd0, N_IO[7:0]}, high word = SYNC_STAGES.
  - Bits at or above N_IO read 0 and ignore writes. Other offsets in the window read 0, ignore writes, and still ack.
- Wishbone handshake:
  - req = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]).
  - Registered ack: ack_next = req & ~ack. This gives exactly one wait state, ack high for one cycle, and never two consecutive ack cycles.
  - Accesses outside the window are never acked.
- Writes:
  - Commit on the clock edge that raises ack.
  - Per-byte: byte k is written only if sel[k] = 1.
  - STATUS write: each 1 bit clears the corresponding status bit; 0 bits have no effect.
- Reads: wbs_dat_o is registered and loaded on the same edge as ack. It holds valid data only while ack = 1 and is 0 otherwise.
- Input path:
  - SYNC_STAGES flop chain per pin, then a prev register holding the last synchronised value.
  - IN reads the last chain stage, so latency from pin to IN is SYNC_STAGES clocks.
- Edge detect:
  - rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
  - Events are suppressed until a 3-bit arm counter reaches SYNC_STAGES + 1 after reset, so a pin held high through reset raises no event.
  - Events are also suppressed while io_active = 0.
- STATUS update: STATUS_next = (STATUS & ~w1c_mask) | rise | fall. If an event and a W1C hit the same bit in the same cycle, the event wins and the bit stays 1.
- irq = |STATUS, an OR of registered bits. irq rises the cycle after the status-setting edge.
- Pad gating:
  - io_active = 1: io_out = OUT and io_oeb = OEB.
  - io_active = 0: io_out = 0 and io_oeb = all 1s. Registers are retained unchanged.
- Reset asserted mid-transaction: ack drops on the next edge and any pending write is discarded.

Test Plan:
1. Reset, then read INFO at BASE + 0x30 -> ack exactly 2 cycles after stb; data 32'h6F10_0026. Read OEB at 0x08/0x0C -> 32'hFFFF_FFFF and 32'h0000_003F.
2. Write OUT low word = 32'hA5A5_A5A5 with sel = 4'b0011, then OEB low = 0, io_active = 1 -> io_out[15:0] = 16'hA5A5, io_out[31:16] = 0. Drop io_active -> io_out = 0, io_oeb = all 1s; raise it again -> previous values restored.
3. RISE_EN[5] = 1; drive io_in[5] 0->1 -> IN[5] = 1 after 2 clocks; STATUS[5] = 1 on the 3rd edge; irq = 1 on the next cycle. A falling edge on pin 5 sets nothing.
4. With STATUS[5] = 1, write 1 to STATUS bit 5 in the same cycle a new rising event occurs -> STATUS[5] stays 1. A later W1C with no event -> STATUS = 0 and irq = 0.
5. Hold io_in = all 1s with RISE_EN = all 1s through reset release -> STATUS stays 0 (arm counter suppression).
6. Access adr = 32'h3000_0100 (outside window) -> no ack for 10 cycles. Access offset 0xF8 -> ack, read 0. Back-to-back stb held for 4 cycles -> ack pattern 0,1,0,1.
